// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract arbiter slice.
//   - arbiter FSM state encoding
//   - requester count
//   - adder mode encoding
package addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned N_REQ = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StExec = ST_EXEC,
    StResp = ST_RESP
  } state_e;

endpackage

// File: rtl/four_bit_adder_subtractor.sv
// Four-bit ripple adder/subtractor (combinational).
// Ports:
//   a, b   : 4-bit operands
//   m      : mode, 0 = a + b, 1 = a - b (computed as a + ~b + 1)
//   sum    : 4-bit result, mod 16
//   carry  : carry-out; for subtract, 1 means no borrow
module four_bit_adder_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] sum,
  output logic       carry
);

  logic [3:0] b_eff;
  logic [4:0] c;

  assign b_eff = b ^ {4{m}};
  assign c[0]  = m;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b_eff[i] ^ c[i];
    assign c[i + 1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
  end

  assign carry = c[4];

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter sharing one four_bit_adder_subtractor.
// One operation in flight: IDLE (grant/accept) -> EXEC (compute) -> RESP (return).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester request handshake (ready is combinational)
//   req_a, req_b        : operands, nibble i belongs to requester i
//   req_m               : mode per requester, 0 = add, 1 = subtract
//   rsp_valid/rsp_ready : per-requester response handshake, one-hot or zero
//   rsp_sum/carry/ovf   : registered result, shared by both requesters
//   busy                : high in EXEC or RESP
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_m,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_sum,
  output logic       rsp_carry,
  output logic       rsp_ovf,
  output logic       busy
);

  state_e     state_q, state_d;
  logic       ptr_q;
  logic       owner_q;
  logic [3:0] a_q, b_q;
  logic       m_q;
  logic [3:0] sum_q;
  logic       carry_q, ovf_q;

  logic       gnt_idx;
  logic       accept;
  logic [3:0] add_sum;
  logic       add_carry;
  logic       ovf_d;

  four_bit_adder_subtractor u_addsub (
    .a     (a_q),
    .b     (b_q),
    .m     (m_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Overflow when the effective operands share a sign and the result's sign differs.
  assign ovf_d = (a_q[3] == (b_q[3] ^ m_q)) & (add_sum[3] != a_q[3]);

  always_comb begin
    gnt_idx   = ptr_q;
    accept    = 1'b0;
    req_ready = 2'b00;
    state_d   = state_q;

    unique case (req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      default: gnt_idx = ptr_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = gnt_idx ? 2'b10 : 2'b01;
          state_d   = StExec;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (rsp_ready[owner_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= RR_INIT;
      owner_q <= 1'b0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      m_q     <= 1'b0;
      sum_q   <= 4'd0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= gnt_idx ? req_a[7:4] : req_a[3:0];
        b_q     <= gnt_idx ? req_b[7:4] : req_b[3:0];
        m_q     <= req_m[gnt_idx];
        owner_q <= gnt_idx;
        ptr_q   <= ~gnt_idx;
      end
      if (state_q == StExec) begin
        sum_q   <= add_sum;
        carry_q <= add_carry;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign rsp_valid = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_m;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_sum;
  logic       rsp_carry;
  logic       rsp_ovf;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(
    .RR_INIT (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_m     (req_m),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  // Reference arithmetic from plain integer math.
  function automatic logic [3:0] ref_sum(input logic [3:0] a, b, input logic m);
    int r;
    r = m ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    return 4'((r + 32) % 16);
  endfunction

  function automatic logic ref_carry(input logic [3:0] a, b, input logic m);
    return m ? (a >= b) : ((int'(a) + int'(b)) > 15);
  endfunction

  function automatic logic ref_ovf(input logic [3:0] a, b, input logic m);
    int sa, sb, r;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    r  = m ? sa - sb : sa + sb;
    return (r > 7) || (r < -8);
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-requester transaction from IDLE, checking handshake timing and result.
  task automatic run_op(input int r, input logic [3:0] a, b, input logic m, input string tag);
    logic [3:0] es;
    logic       ec, eo;
    logic [1:0] oh;
    es = ref_sum(a, b, m);
    ec = ref_carry(a, b, m);
    eo = ref_ovf(a, b, m);
    oh = (r == 1) ? 2'b10 : 2'b01;
    req_valid[r]       = 1'b1;
    req_a[4*r +: 4]    = a;
    req_b[4*r +: 4]    = b;
    req_m[r]           = m;
    #1;
    n_checks++;
    if (req_ready !== oh) begin
      n_fail++;
      $display("FAIL %s req_ready: got %b want %b", tag, req_ready, oh);
    end
    tick();
    // Operands are free to change after acceptance.
    req_valid[r]    = 1'b0;
    req_a[4*r +: 4] = 4'($urandom);
    req_b[4*r +: 4] = 4'($urandom);
    req_m[r]        = 1'($urandom);
    #1;
    n_checks++;
    if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL %s exec: got busy=%b rsp_valid=%b want busy=1 rsp_valid=00",
               tag, busy, rsp_valid);
    end
    tick();
    n_checks++;
    if (rsp_valid !== oh || rsp_sum !== es || rsp_carry !== ec || rsp_ovf !== eo) begin
      n_fail++;
      $display("FAIL %s resp: got v=%b s=%h c=%b o=%b want v=%b s=%h c=%b o=%b", tag,
               rsp_valid, rsp_sum, rsp_carry, rsp_ovf, oh, es, ec, eo);
    end
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: got rsp_valid=%b busy=%b want 00 0", tag, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00 || rsp_sum !== 4'd0 || rsp_carry !== 1'b0 ||
        rsp_ovf !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset: got v=%b s=%h c=%b o=%b busy=%b rdy=%b want all zero",
               rsp_valid, rsp_sum, rsp_carry, rsp_ovf, busy, req_ready);
    end
  endtask

  task automatic test_add();
    run_op(0, 4'd3, 4'd4, 1'b0, "add_3_4");
  endtask

  task automatic test_sub();
    run_op(1, 4'd2, 4'd5, 1'b1, "sub_2_5");
    run_op(1, 4'd5, 4'd2, 1'b1, "sub_5_2");
  endtask

  task automatic test_overflow();
    run_op(0, 4'd7, 4'd1, 1'b0, "ovf_add");
    run_op(0, 4'h8, 4'd1, 1'b1, "ovf_sub");
  endtask

  // Both requesters valid throughout; grants must alternate starting at 0.
  task automatic test_contention();
    int         exp_g;
    logic [3:0] ea, eb;
    logic       em;
    logic [1:0] oh;
    test_reset();
    exp_g     = 0;
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    req_m     = 2'($urandom);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    for (int k = 0; k < 6; k++) begin
      #1;
      oh = (exp_g == 1) ? 2'b10 : 2'b01;
      ea = req_a[4*exp_g +: 4];
      eb = req_b[4*exp_g +: 4];
      em = req_m[exp_g];
      n_checks++;
      if (req_ready !== oh) begin
        n_fail++;
        $display("FAIL contention grant %0d: got req_ready=%b want %b", k, req_ready, oh);
      end
      tick();
      req_a[4*exp_g +: 4] = 4'($urandom);
      req_b[4*exp_g +: 4] = 4'($urandom);
      req_m[exp_g]        = 1'($urandom);
      tick();
      // RESP with ready on both bits and both requests pending: no accept this cycle.
      rsp_ready = 2'b11;
      #1;
      n_checks++;
      if (rsp_valid !== oh || req_ready !== 2'b00 || rsp_sum !== ref_sum(ea, eb, em) ||
          rsp_carry !== ref_carry(ea, eb, em) || rsp_ovf !== ref_ovf(ea, eb, em)) begin
        n_fail++;
        $display("FAIL contention resp %0d: got v=%b rdy=%b s=%h c=%b o=%b want v=%b rdy=00 s=%h c=%b o=%b",
                 k, rsp_valid, req_ready, rsp_sum, rsp_carry, rsp_ovf, oh,
                 ref_sum(ea, eb, em), ref_carry(ea, eb, em), ref_ovf(ea, eb, em));
      end
      tick();
      rsp_ready = 2'b00;
      exp_g     = 1 - exp_g;
    end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_backpressure();
    logic [3:0] a, b, es;
    a  = 4'($urandom);
    b  = 4'($urandom);
    es = ref_sum(a, b, 1'b0);
    req_valid[0] = 1'b1;
    req_a[3:0]   = a;
    req_b[3:0]   = b;
    req_m[0]     = 1'b0;
    tick();
    req_valid = 2'b00;
    tick();
    for (int k = 0; k < 7; k++) begin
      // Last two cycles: ready on the non-owner bit, which must be ignored.
      rsp_ready = (k >= 5) ? 2'b10 : 2'b00;
      req_valid = 2'($urandom);
      #1;
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_sum !== es || req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure %0d: got v=%b s=%h rdy=%b busy=%b want v=01 s=%h rdy=00 busy=1",
                 k, rsp_valid, rsp_sum, req_ready, busy, es);
      end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure release: got v=%b busy=%b want 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset_midop();
    req_valid[0] = 1'b1;
    req_a[3:0]   = 4'd9;
    req_b[3:0]   = 4'd9;
    req_m[0]     = 1'b0;
    tick();
    req_valid = 2'b00;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_sum !== 4'd0 ||
        rsp_carry !== 1'b0 || rsp_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: got v=%b busy=%b s=%h c=%b o=%b want zeros",
               rsp_valid, busy, rsp_sum, rsp_carry, rsp_ovf);
    end
    run_op(1, 4'd6, 4'd3, 1'b1, "post_reset_req1");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_op(int'($urandom_range(1, 0)), 4'($urandom), 4'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = 8'd0;
    req_b     = 8'd0;
    req_m     = 2'b00;
    rsp_ready = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
